icache: RTL
===========

ICACHE -- requirements
Module: icache

Interface
REQ-001 SHALL have parameter NFRAMES, default 16, number of direct-mapped one-word frames (power of two).
REQ-002 SHALL have port CLK  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port nRST  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port imemREN  input  1  datapath instruction read request.
REQ-005 SHALL have port imemaddr  input  32  datapath fetch address (PC).
REQ-006 SHALL have port ihit  output  1  requested word valid on imemload this cycle.
REQ-007 SHALL have port imemload  output  32  instruction word to datapath.
REQ-008 SHALL have port iREN  output  1  read request to memory controller.
REQ-009 SHALL have port iaddr  output  32  word address to memory controller.
REQ-010 SHALL have port iwait  input  1  memory busy; iload valid in the cycle iwait=0 while iREN=1.
REQ-011 SHALL have port iload  input  32  instruction word from memory controller.

Function
REQ-012 SHALL decode address as byte offset [1:0] (ignored), index [log2(NFRAMES)+1:2], tag [31:log2(NFRAMES)+2].
REQ-013 SHALL hold per frame: valid bit, tag, 32-bit data.
REQ-014 SHALL implement FSM with states IDLE and FETCH; reset state IDLE.
REQ-015 IDLE: imemREN=1 and indexed frame valid with matching tag -> ihit=1 and imemload=frame data combinationally in the same cycle; state stays IDLE.
REQ-016 IDLE: imemREN=1 and miss -> capture imemaddr into a miss-address register, next state FETCH; ihit=0.
REQ-017 IDLE: imemREN=0 -> ihit=0, no state change.
REQ-018 FETCH: iREN=1, iaddr = captured miss address with [1:0]=00; ihit=0.
REQ-019 FETCH with iwait=0: write valid=1, tag, data=iload into frame at captured index; next state IDLE.
REQ-020 FETCH with iwait=1: hold state; iREN and iaddr stable.
REQ-021 Miss latency: ihit asserts in the first IDLE cycle after fill, i.e. (memory wait cycles + 2) cycles after the miss cycle.
REQ-022 imemaddr change or imemREN deassert during FETCH SHALL NOT abort the fill; fill completes to captured address, then IDLE re-evaluates current imemaddr.
REQ-023 Fill overwrites a valid frame at the same index unconditionally (conflict eviction).
REQ-024 imemload SHALL be 0 whenever ihit=0.
REQ-025 In IDLE, iREN=0 and iaddr=0.

Reset
REQ-026 nRST=1 at a rising edge SHALL clear all valid bits, tags and data to 0, clear the miss-address register, and force IDLE.
REQ-027 Reset values: ihit=0, imemload=0, iREN=0, iaddr=0.
REQ-028 Reset asserted during FETCH SHALL abandon the fill: no frame written, iREN=0 from the next cycle.
REQ-029 nRST asserted with iwait=0 in FETCH: reset wins; frame not written.

Structure
REQ-030 word_t and the constants ITAG_W and IIDX_W, plus typedef icache_frame_t {valid, tag, data}, SHALL live in cpu_types_pkg.
REQ-031 The FSM state enum SHALL be local to icache.
REQ-032 SHALL be a single module; no sub-module.

Verification
REQ-033 Reset, then imemREN=1, imemaddr=0x00000000 -> ihit=0, iREN=1, iaddr=0x00000000 next cycle; iwait=0, iload=0x8C010004 -> following cycle ihit=1, imemload=0x8C010004.
REQ-034 Re-read 0x00000000 with iREN never asserting -> ihit=1 same cycle.
REQ-035 Conflict: fill 0x00000040 (index 0, NFRAMES=16) with 0x12345678, then read 0x00000000 -> miss, iREN=1, iaddr=0x00000000.
REQ-036 Miss with iwait=1 for 5 cycles, imemaddr changed to 0x00000008 mid-fetch -> iaddr stays 0x00000004; after fill, IDLE misses on 0x00000008.
REQ-037 Reset asserted in FETCH with iwait=0 -> iREN=0 next cycle, later read of same address misses.
REQ-038 Address 0xFFFFFFFF -> iaddr=0xFFFFFFFC, fills index 15, tag all ones; re-read 0xFFFFFFFC hits.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word and the instruction-cache frame layout.
// Frame geometry matches the default 16-frame cache (4 index bits, 26 tag bits).
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam int IIDX_W = 4;
  localparam int ITAG_W = 32 - IIDX_W - 2;

  typedef struct packed {
    logic              valid;
    logic [ITAG_W-1:0] tag;
    word_t             data;
  } icache_frame_t;

endpackage

// File: rtl/icache.sv
// Direct-mapped, one-word-per-frame instruction cache. Hits are answered
// combinationally in IDLE; a miss parks in FETCH until memory drops iwait.
module icache
  import cpu_types_pkg::*;
#(
  parameter int NFRAMES = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);

  localparam int IDX_W = $clog2(NFRAMES);

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  state_t        r_state;
  word_t         r_miss_addr;
  icache_frame_t r_frames [NFRAMES];

  logic [IDX_W-1:0]  w_idx;
  logic [ITAG_W-1:0] w_tag;
  logic [IDX_W-1:0]  w_miss_idx;
  logic [ITAG_W-1:0] w_miss_tag;
  icache_frame_t     w_frame;
  logic              w_hit;
  logic              w_unused_lsb;

  assign w_idx        = imemaddr[IDX_W+1:2];
  assign w_tag        = ITAG_W'(imemaddr[31:IDX_W+2]);
  assign w_miss_idx   = r_miss_addr[IDX_W+1:2];
  assign w_miss_tag   = ITAG_W'(r_miss_addr[31:IDX_W+2]);
  assign w_frame      = r_frames[w_idx];
  // The byte offset never selects anything in a word-granular cache.
  assign w_unused_lsb = ^imemaddr[1:0];

  assign w_hit = (r_state == IDLE) && imemREN && w_frame.valid && (w_frame.tag == w_tag);

  assign ihit     = w_hit;
  assign imemload = w_hit ? w_frame.data : 32'h0;
  assign iREN     = (r_state == FETCH);
  assign iaddr    = (r_state == FETCH) ? r_miss_addr : 32'h0;

  // Reset takes priority over a completing fill, so a fill in flight is dropped.
  always_ff @(posedge CLK) begin
    if (nRST) begin
      r_state     <= IDLE;
      r_miss_addr <= '0;
      for (int i = 0; i < NFRAMES; i++) begin
        r_frames[i] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (imemREN && !w_hit) begin
            r_miss_addr <= {imemaddr[31:2], 2'b00};
            r_state     <= FETCH;
          end
        end
        FETCH: begin
          if (!iwait) begin
            r_frames[w_miss_idx] <= '{valid: 1'b1, tag: w_miss_tag, data: iload};
            r_state              <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
